// File: rtl/fifo_arbiter.sv
// Scheduler for the interconnect FIFO bank: configuration sequencing plus round-robin
// arbitration of input FIFOs onto one word-wide path routed by each word's class field.
module fifo_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 2,
    parameter int WORD_SIZE = 6,
    parameter int PTR_L     = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          init,
    input  logic [PTR_L-1:0]              full_threshold_in,
    input  logic [PTR_L-1:0]              empty_threshold_in,
    input  logic [NUM_CH-1:0]             in_empty,
    input  logic [NUM_CH*WORD_SIZE-1:0]   in_data,
    input  logic [NUM_CH-1:0]             out_almost_full,
    input  logic [NUM_CH*2-1:0]           fifo_error,
    output logic [NUM_CH-1:0]             in_pop,
    output logic [NUM_CH-1:0]             out_push,
    output logic [WORD_SIZE-1:0]          out_data,
    output logic [PTR_L-1:0]              full_threshold,
    output logic [PTR_L-1:0]              empty_threshold,
    output logic [2:0]                    state,
    output logic                          idle,
    output logic [CH_W-1:0]               active_ch
);

    localparam logic [2:0] ST_RESET  = 3'b000;
    localparam logic [2:0] ST_INIT   = 3'b001;
    localparam logic [2:0] ST_IDLE   = 3'b010;
    localparam logic [2:0] ST_ACTIVE = 3'b011;
    localparam logic [2:0] ST_ERROR  = 3'b100;

    logic [2:0]           state_q, state_d;
    logic [CH_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]      active_ch_q, active_ch_d;
    logic [NUM_CH-1:0]    out_push_q, out_push_d;
    logic [WORD_SIZE-1:0] out_data_q, out_data_d;
    logic [PTR_L-1:0]     full_thr_q, full_thr_d;
    logic [PTR_L-1:0]     empty_thr_q, empty_thr_d;

    logic [CH_W-1:0]      dest_s [NUM_CH];
    logic [WORD_SIZE-1:0] word_s [NUM_CH];
    logic [NUM_CH-1:0]    elig_s;
    logic [CH_W-1:0]      scan_idx_s;
    logic                 gnt_valid_s;
    logic [CH_W-1:0]      gnt_ch_s;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; IDLE and ACTIVE share the same exit rules
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (init) state_d = ST_INIT;
                else      state_d = ST_IDLE;
            end
            ST_IDLE, ST_ACTIVE: begin
                if (|fifo_error)    state_d = ST_ERROR;
                else if (init)      state_d = ST_INIT;
                else if (&in_empty) state_d = ST_IDLE;
                else                state_d = ST_ACTIVE;
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RESET;
        endcase
    end

    // Per-channel destination class and eligibility under output backpressure
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            word_s[i] = in_data[i*WORD_SIZE +: WORD_SIZE];
            dest_s[i] = in_data[i*WORD_SIZE + WORD_SIZE-1 -: CH_W];
            elig_s[i] = ~in_empty[i] & ~out_almost_full[dest_s[i]];
        end
    end

    // Round-robin scan starting at rr_ptr; only ACTIVE may grant
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_ch_s    = '0;
        scan_idx_s  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan_idx_s = rr_ptr_q + CH_W'(k);
            if (!gnt_valid_s && elig_s[scan_idx_s] && (state_q == ST_ACTIVE)) begin
                gnt_valid_s = 1'b1;
                gnt_ch_s    = scan_idx_s;
            end else begin
                gnt_valid_s = gnt_valid_s;
                gnt_ch_s    = gnt_ch_s;
            end
        end
    end

    // Datapath and configuration next-state
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        active_ch_d = active_ch_q;
        out_data_d  = out_data_q;
        out_push_d  = '0;
        full_thr_d  = full_thr_q;
        empty_thr_d = empty_thr_q;
        if (gnt_valid_s) begin
            out_data_d  = word_s[gnt_ch_s];
            out_push_d  = {{(NUM_CH-1){1'b0}}, 1'b1} << dest_s[gnt_ch_s];
            rr_ptr_d    = gnt_ch_s + CH_W'(1);
            active_ch_d = gnt_ch_s;
        end else begin
            out_push_d  = '0;
        end
        if (state_q == ST_INIT) begin
            full_thr_d  = full_threshold_in;
            empty_thr_d = empty_threshold_in;
        end else begin
            full_thr_d  = full_thr_q;
            empty_thr_d = empty_thr_q;
        end
    end

    // Datapath and configuration registers; reset drops any pending push
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            active_ch_q <= '0;
            out_data_q  <= '0;
            out_push_q  <= '0;
            full_thr_q  <= '0;
            empty_thr_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            active_ch_q <= active_ch_d;
            out_data_q  <= out_data_d;
            out_push_q  <= out_push_d;
            full_thr_q  <= full_thr_d;
            empty_thr_q <= empty_thr_d;
        end
    end

    // Combinational outputs
    always_comb begin
        if (gnt_valid_s) begin
            in_pop = {{(NUM_CH-1){1'b0}}, 1'b1} << gnt_ch_s;
        end else begin
            in_pop = '0;
        end
        idle = (state_q == ST_IDLE) && (&in_empty);
    end

    assign state           = state_q;
    assign out_push        = out_push_q;
    assign out_data        = out_data_q;
    assign full_threshold  = full_thr_q;
    assign empty_threshold = empty_thr_q;
    assign active_ch       = active_ch_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Self-checking bench for fifo_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the scheduling rules.
module tb_fifo_arbiter;

    logic        clk;
    logic        reset;
    logic        init;
    logic [2:0]  full_threshold_in, empty_threshold_in;
    logic [3:0]  in_empty;
    logic [23:0] in_data;
    logic [3:0]  out_almost_full;
    logic [7:0]  fifo_error;
    logic [3:0]  in_pop, out_push;
    logic [5:0]  out_data;
    logic [2:0]  full_threshold, empty_threshold;
    logic [2:0]  state;
    logic        idle;
    logic [1:0]  active_ch;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         m_state, m_rr, m_active;
    logic [3:0] m_push;
    logic [5:0] m_data;
    logic [2:0] m_fth, m_eth;

    fifo_arbiter #(.NUM_CH(4), .CH_W(2), .WORD_SIZE(6), .PTR_L(3)) dut (
        .clk(clk), .reset(reset), .init(init),
        .full_threshold_in(full_threshold_in), .empty_threshold_in(empty_threshold_in),
        .in_empty(in_empty), .in_data(in_data), .out_almost_full(out_almost_full),
        .fifo_error(fifo_error), .in_pop(in_pop), .out_push(out_push), .out_data(out_data),
        .full_threshold(full_threshold), .empty_threshold(empty_threshold),
        .state(state), .idle(idle), .active_ch(active_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dest_of(int c);
        logic [1:0] d;
        d = in_data[c*6+4 +: 2];
        return int'(d);
    endfunction

    function automatic logic [5:0] word_of(int c);
        return in_data[c*6 +: 6];
    endfunction

    // Channel granted this cycle, or -1
    function automatic int model_grant();
        int c;
        if (m_state != 3) return -1;
        for (int k = 0; k < 4; k++) begin
            c = (m_rr + k) % 4;
            if (!in_empty[c] && !out_almost_full[dest_of(c)]) return c;
        end
        return -1;
    endfunction

    function automatic int model_next_state();
        case (m_state)
            0: return 1;
            1: return init ? 1 : 2;
            2, 3: begin
                if (|fifo_error) return 4;
                if (init) return 1;
                return (&in_empty) ? 2 : 3;
            end
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] exp_pop();
        int g;
        g = model_grant();
        return (g >= 0) ? (4'b0001 << g) : 4'b0000;
    endfunction

    // Advance one clock edge and update the model; returns at posedge+1
    task automatic tick();
        int g, ns, d;
        logic [5:0] w;
        g  = model_grant();
        ns = model_next_state();
        d  = (g >= 0) ? dest_of(g) : 0;
        w  = (g >= 0) ? word_of(g) : 6'd0;
        @(posedge clk);
        if (reset) begin
            m_state = 0; m_rr = 0; m_active = 0; m_push = 4'd0; m_data = 6'd0; m_fth = 3'd0; m_eth = 3'd0;
        end else begin
            if (m_state == 1) begin m_fth = full_threshold_in; m_eth = empty_threshold_in; end
            if (g >= 0) begin
                m_data = w; m_push = 4'b0001 << d; m_rr = (g + 1) % 4; m_active = g;
            end else begin
                m_push = 4'd0;
            end
            m_state = ns;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; init = 1'b0; in_empty = 4'hF; in_data = 24'd0;
        out_almost_full = 4'd0; fifo_error = 8'd0; full_threshold_in = 3'd0; empty_threshold_in = 3'd0;
        tick(); tick();
        checks++; if (state !== 3'b000) begin errors++; $display("FAIL reset_state: got %b exp 000", state); end
        checks++; if (out_push !== 4'd0) begin errors++; $display("FAIL reset_push: got %b exp 0000", out_push); end
        checks++; if (out_data !== 6'd0) begin errors++; $display("FAIL reset_data: got %h exp 00", out_data); end
        checks++; if ({full_threshold, empty_threshold, active_ch} !== 8'd0) begin errors++; $display("FAIL reset_regs: got %h exp 00", {full_threshold, empty_threshold, active_ch}); end
        checks++; if (in_pop !== 4'd0) begin errors++; $display("FAIL reset_pop: got %b exp 0000", in_pop); end
    endtask

    task automatic test_init();
        reset = 1'b0; init = 1'b1; full_threshold_in = 3'd5; empty_threshold_in = 3'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (state !== 3'b001) begin errors++; $display("FAIL init_state%0d: got %b exp 001", i, state); end
        end
        checks++; if (in_pop !== 4'd0) begin errors++; $display("FAIL init_pop: got %b exp 0000", in_pop); end
        init = 1'b0;
        tick();
        checks++; if (state !== 3'b010) begin errors++; $display("FAIL init_to_idle: got %b exp 010", state); end
        checks++; if (full_threshold !== 3'd5) begin errors++; $display("FAIL full_thr: got %0d exp 5", full_threshold); end
        checks++; if (empty_threshold !== 3'd1) begin errors++; $display("FAIL empty_thr: got %0d exp 1", empty_threshold); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL idle_high: got %b exp 1", idle); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] words [4];
        for (int i = 0; i < 4; i++) begin
            words[i] = {2'((i + 1) % 4), 4'(i * 3 + 1)};
            in_data[i*6 +: 6] = words[i];
        end
        in_empty = 4'h0; out_almost_full = 4'h0;
        #1;
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL b2b_idle_low: got %b exp 0", idle); end
        tick();
        checks++; if (state !== 3'b011) begin errors++; $display("FAIL b2b_active: got %b exp 011", state); end
        for (int c = 0; c < 8; c++) begin
            checks++; if (in_pop !== (4'b0001 << (c % 4))) begin errors++; $display("FAIL b2b_pop%0d: got %b exp %b", c, in_pop, 4'b0001 << (c % 4)); end
            tick();
            checks++; if (out_push !== (4'b0001 << ((c % 4 + 1) % 4))) begin errors++; $display("FAIL b2b_push%0d: got %b exp %b", c, out_push, 4'b0001 << ((c % 4 + 1) % 4)); end
            checks++; if (out_data !== words[c % 4]) begin errors++; $display("FAIL b2b_data%0d: got %h exp %h", c, out_data, words[c % 4]); end
            checks++; if (active_ch !== 2'(c % 4)) begin errors++; $display("FAIL b2b_active_ch%0d: got %0d exp %0d", c, active_ch, c % 4); end
        end
        in_empty = 4'hF;
        tick();
        checks++; if (state !== 3'b010 || out_push !== 4'd0) begin errors++; $display("FAIL b2b_to_idle: got state %b push %b exp 010 0000", state, out_push); end
    endtask

    task automatic test_single();
        in_data = 24'd0; in_data[11:6] = 6'b100111; in_empty = 4'b1101;
        #1;
        checks++; if (in_pop !== 4'd0) begin errors++; $display("FAIL single_idle_pop: got %b exp 0000", in_pop); end
        tick();
        checks++; if (state !== 3'b011) begin errors++; $display("FAIL single_state: got %b exp 011", state); end
        checks++; if (in_pop !== 4'b0010) begin errors++; $display("FAIL single_pop: got %b exp 0010", in_pop); end
        tick();
        checks++; if (out_push !== 4'b0100) begin errors++; $display("FAIL single_push: got %b exp 0100", out_push); end
        checks++; if (out_data !== 6'b100111) begin errors++; $display("FAIL single_data: got %b exp 100111", out_data); end
        checks++; if (active_ch !== 2'd1) begin errors++; $display("FAIL single_active_ch: got %0d exp 1", active_ch); end
        in_empty = 4'hF;
        tick();
        checks++; if (state !== 3'b010) begin errors++; $display("FAIL single_to_idle: got %b exp 010", state); end
    endtask

    task automatic test_backpressure();
        in_data = 24'd0;
        in_data[5:0] = 6'b110001; in_data[11:6] = 6'b000010; in_data[17:12] = 6'b110011;
        in_empty = 4'b1000; out_almost_full = 4'b1000;
        tick();
        checks++; if (in_pop !== 4'b0010) begin errors++; $display("FAIL bp_only_ch1: got %b exp 0010", in_pop); end
        tick();
        checks++; if (out_push !== 4'b0001 || out_data !== 6'b000010) begin errors++; $display("FAIL bp_ch1_push: got %b/%b exp 0001/000010", out_push, out_data); end
        in_empty = 4'b1010; out_almost_full = 4'b0000;
        #1;
        checks++; if (in_pop !== 4'b0100) begin errors++; $display("FAIL bp_ch2_first: got %b exp 0100", in_pop); end
        tick();
        checks++; if (out_push !== 4'b1000 || out_data !== 6'b110011 || active_ch !== 2'd2) begin errors++; $display("FAIL bp_ch2_push: got %b/%b/%0d exp 1000/110011/2", out_push, out_data, active_ch); end
        checks++; if (in_pop !== 4'b0001) begin errors++; $display("FAIL bp_ch0_next: got %b exp 0001", in_pop); end
        tick();
        checks++; if (out_push !== 4'b1000 || out_data !== 6'b110001 || active_ch !== 2'd0) begin errors++; $display("FAIL bp_ch0_push: got %b/%b/%0d exp 1000/110001/0", out_push, out_data, active_ch); end
        in_empty = 4'hF;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            in_empty = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            in_data = 24'($urandom);
            out_almost_full = 4'($urandom & $urandom);
            init = ($urandom_range(0, 39) == 0);
            full_threshold_in = 3'($urandom); empty_threshold_in = 3'($urandom);
            #1;
            checks++; if (in_pop !== exp_pop()) begin errors++; $display("FAIL rnd_pop%0d: got %b exp %b", n, in_pop, exp_pop()); end
            checks++; if (idle !== (m_state == 2 && &in_empty)) begin errors++; $display("FAIL rnd_idle%0d: got %b", n, idle); end
            checks++; if ((in_pop & in_empty) !== 4'd0 || $countones(in_pop) > 1) begin errors++; $display("FAIL rnd_pop_legal%0d: got %b empty %b", n, in_pop, in_empty); end
            tick();
            checks++; if (state !== 3'(m_state)) begin errors++; $display("FAIL rnd_state%0d: got %b exp %0d", n, state, m_state); end
            checks++; if (out_push !== m_push || out_data !== m_data) begin errors++; $display("FAIL rnd_out%0d: got %b/%h exp %b/%h", n, out_push, out_data, m_push, m_data); end
            checks++; if (active_ch !== 2'(m_active)) begin errors++; $display("FAIL rnd_active_ch%0d: got %0d exp %0d", n, active_ch, m_active); end
            checks++; if (full_threshold !== m_fth || empty_threshold !== m_eth) begin errors++; $display("FAIL rnd_thr%0d: got %0d/%0d exp %0d/%0d", n, full_threshold, empty_threshold, m_fth, m_eth); end
        end
        init = 1'b0; in_empty = 4'hF; out_almost_full = 4'd0;
        tick(); tick();
        checks++; if (state !== 3'b010) begin errors++; $display("FAIL rnd_settle: got %b exp 010", state); end
    endtask

    task automatic test_error();
        in_data = 24'd0; in_data[5:0] = 6'b010101; in_empty = 4'b1110;
        tick();
        checks++; if (state !== 3'b011) begin errors++; $display("FAIL err_active: got %b exp 011", state); end
        fifo_error = 8'h10;
        #1;
        checks++; if (in_pop !== 4'b0001) begin errors++; $display("FAIL err_pop: got %b exp 0001", in_pop); end
        tick();
        fifo_error = 8'h00;
        checks++; if (state !== 3'b100) begin errors++; $display("FAIL err_state: got %b exp 100", state); end
        checks++; if (out_push !== 4'b0010 || out_data !== 6'b010101) begin errors++; $display("FAIL err_last_push: got %b/%b exp 0010/010101", out_push, out_data); end
        in_empty = 4'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_pop !== 4'd0) begin errors++; $display("FAIL err_no_pop%0d: got %b exp 0000", i, in_pop); end
            tick();
            checks++; if (state !== 3'b100 || out_push !== 4'd0) begin errors++; $display("FAIL err_trap%0d: got %b/%b exp 100/0000", i, state, out_push); end
        end
        reset = 1'b1;
        tick();
        checks++; if (state !== 3'b000 || out_push !== 4'd0 || out_data !== 6'd0) begin errors++; $display("FAIL err_reset: got %b/%b/%h exp 000/0000/00", state, out_push, out_data); end
        checks++; if ({full_threshold, empty_threshold, active_ch} !== 8'd0) begin errors++; $display("FAIL err_reset_regs: got %h exp 00", {full_threshold, empty_threshold, active_ch}); end
        reset = 1'b0; in_empty = 4'hF;
    endtask

    task automatic test_reset_drop();
        init = 1'b1; full_threshold_in = 3'd3; empty_threshold_in = 3'd2;
        tick();
        init = 1'b0;
        tick();
        checks++; if (state !== 3'b010 || full_threshold !== 3'd3 || empty_threshold !== 3'd2) begin errors++; $display("FAIL drop_init: got %b/%0d/%0d exp 010/3/2", state, full_threshold, empty_threshold); end
        in_data = 24'd0; in_data[17:12] = 6'b110001; in_empty = 4'b1011;
        tick();
        checks++; if (in_pop !== 4'b0100) begin errors++; $display("FAIL drop_pop: got %b exp 0100", in_pop); end
        tick();
        in_empty = 4'hF;
        checks++; if (out_push !== 4'b1000) begin errors++; $display("FAIL drop_pending: got %b exp 1000", out_push); end
        reset = 1'b1;
        tick();
        checks++; if (out_push !== 4'd0 || out_data !== 6'd0 || state !== 3'b000) begin errors++; $display("FAIL drop_cleared: got %b/%h/%b exp 0000/00/000", out_push, out_data, state); end
        reset = 1'b0;
    endtask

    initial begin
        m_state = 0; m_rr = 0; m_active = 0; m_push = 4'd0; m_data = 6'd0; m_fth = 3'd0; m_eth = 3'd0;
        test_reset();
        test_init();
        test_back_to_back();
        test_single();
        test_backpressure();
        test_random();
        test_error();
        test_reset_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_arbiter.md
Name: fifo_arbiter

Overview:
- Control and scheduling block for the interconnect FIFO bank.
- Sequences configuration: RESET, then INIT (loads almost-full/almost-empty thresholds distributed to all FIFOs), then IDLE/ACTIVE, with an ERROR trap.
- In ACTIVE, round-robin arbitrates NUM_CH input FIFOs onto a shared one-word datapath and routes each word to one of NUM_CH output FIFOs selected by the word's class field.
- Applies backpressure from output almost_full flags.

Parameters:
- NUM_CH, 4: input and output FIFO count. Fixed at 4 in this revision.
- CH_W, 2: width of channel index and class field; log2(NUM_CH).
- WORD_SIZE, 6: word width; bits [WORD_SIZE-1 -: CH_W] are the destination class.
- PTR_L, 3: threshold width.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- init  in  1  request to enter or stay in INIT and load thresholds.
- full_threshold_in  in  PTR_L  almost-full threshold to load.
- empty_threshold_in  in  PTR_L  almost-empty threshold to load.
- in_empty  in  NUM_CH  empty flags of input FIFOs.
- in_data  in  NUM_CH*WORD_SIZE  head words of input FIFOs; channel i at [i*WORD_SIZE +: WORD_SIZE].
- out_almost_full  in  NUM_CH  almost-full flags of output FIFOs.
- fifo_error  in  NUM_CH*2  error flags of all input and output FIFOs.
- in_pop  out  NUM_CH  combinational pop strobe, one-hot or zero.
- out_push  out  NUM_CH  registered push strobe, one-hot or zero.
- out_data  out  WORD_SIZE  registered word accompanying out_push.
- full_threshold  out  PTR_L  registered threshold to all FIFOs.
- empty_threshold  out  PTR_L  registered threshold to all FIFOs.
- state  out  3  current FSM state.
- idle  out  1  high in IDLE when all in_empty=1.
- active_ch  out  CH_W  last granted channel.

Behaviour:
Reset:
- reset sampled high at a clock edge: state=RESET, and all registered outputs, thresholds, rr_ptr and active_ch go to 0.
- Any pending push is discarded.
- in_pop=0 while state!=ACTIVE.

State encoding: RESET=000, INIT=001, IDLE=010, ACTIVE=011, ERROR=100.

Transition priority: reset > error > init > others.
- RESET -> INIT: first cycle with reset low.
- INIT: thresholds <= *_in every cycle. Stay while init=1. init=0 -> IDLE.
- IDLE: idle=1 iff &in_empty.
  - Any in_empty bit 0 -> ACTIVE.
  - init=1 -> INIT.
- ACTIVE:
  - &in_empty -> IDLE.
  - init=1 -> INIT.
- |fifo_error in IDLE or ACTIVE -> ERROR.
- ERROR exits only via reset. Thresholds are held in ERROR.

Arbitration (ACTIVE only, combinational within cycle N):
- dest(i) = in_data[i*WORD_SIZE + WORD_SIZE-1 -: CH_W].
- Channel i is eligible iff in_empty[i]=0 and out_almost_full[dest(i)]=0.
- Grant g = first eligible channel scanning rr_ptr, rr_ptr+1, ... mod NUM_CH.
- in_pop[g]=1. At most one pop per cycle.

Cycle N edge, on a grant:
- out_data <= in_data[g]; out_push <= onehot(dest(g)).
- rr_ptr <= g+1 mod NUM_CH (wraps 3 -> 0); active_ch <= g.

No grant:
- out_push <= 0.
- rr_ptr and out_data hold.

Latency and throughput:
- Pop to push is exactly 1 cycle.
- Back-to-back grants are allowed: one word per cycle throughput.

Backpressure:
- almost_full is sampled at pop time, and one word may still be in flight.
- Output FIFOs must assert almost_full with at least 2 free entries. The integrator guarantees this via full_threshold.

Leaving ACTIVE (to IDLE, INIT or ERROR):
- No new pop in the leaving cycle's successor state.
- A push registered in the last ACTIVE cycle still issues in the next cycle; no data loss.

Invariants:
- in_pop[i] is never 1 while in_empty[i]=1.
- out_push is never multi-hot.

Test Plan:
1. Reset then init for 3 cycles with full_threshold_in=5, empty_threshold_in=1, then init=0 -> state 000, 001, 001, 001, 010; full_threshold=5, empty_threshold=1; idle=1 with all in_empty=1.
2. Ch1 non-empty, head word 6'b10_0111 -> state->011, in_pop=0010, next cycle out_push=0100 and out_data=6'b100111, active_ch=1, rr_ptr=2.
3. All 4 inputs non-empty, distinct dests, no backpressure, 8 cycles -> grant order 0,1,2,3,0,1,2,3; one pop per cycle; each push 1 cycle after its pop.
4. Ch0 and ch2 both target output 3, out_almost_full[3]=1, ch1 targets output 0 -> only ch1 popped; after almost_full[3] drops, ch2 granted before ch0 if rr_ptr=2.
5. fifo_error bit 4 pulses during ACTIVE with a pop in the same cycle -> that word still pushed next cycle, state=100; no further pops until reset; reset -> state 000, all outputs 0.
6. reset asserted the cycle after a pop -> out_push=0 and out_data=0 after the reset edge; the pending word is dropped.
